// File: rtl/wolfram_ca_engine.sv
// One-dimensional, two-state Wolfram cellular automaton: computes one generation per clock.
// Define CA_FIXPOINT_DETECT_EN to add early termination on a stable state (fixpoint output).
module wolfram_ca_engine #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rule,
  input  logic             periodic,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             start,
  input  logic [GEN_W-1:0] n_gens,
  input  logic             abort,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] state,
  output logic [GEN_W-1:0] gen_count
`ifdef CA_FIXPOINT_DETECT_EN
  ,
  output logic             fixpoint
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} fsm_e;

  fsm_e             fsm_q, fsm_d;
  logic [WIDTH-1:0] state_q, state_d, next_gen;
  logic [GEN_W-1:0] gen_q, gen_d, gen_inc, n_gens_q, n_gens_d;
  logic [7:0]       rule_q, rule_d;
  logic             periodic_q, periodic_d;
  logic [WIDTH+1:0] ext;
`ifdef CA_FIXPOINT_DETECT_EN
  logic             fix_q, fix_d;
`endif

  // ext[0] is the right boundary, ext[WIDTH+1] the left one; cell i sees ext[i+2:i].
  always_comb begin
    ext      = {periodic_q & state_q[0], state_q, periodic_q & state_q[WIDTH-1]};
    next_gen = '0;
    for (int i = 0; i < WIDTH; i++) begin
      next_gen[i] = rule_q[ext[i +: 3]];
    end
  end

  // gen_q is always below n_gens_q while running, so the increment cannot wrap.
  assign gen_inc = gen_q + GEN_W'(1);

  always_comb begin
    fsm_d      = fsm_q;
    state_d    = state_q;
    gen_d      = gen_q;
    n_gens_d   = n_gens_q;
    rule_d     = rule_q;
    periodic_d = periodic_q;
`ifdef CA_FIXPOINT_DETECT_EN
    fix_d      = fix_q;
`endif
    unique case (fsm_q)
      StIdle: begin
        if (load) begin
          state_d = seed;
        end else if (start) begin
          rule_d     = rule;
          periodic_d = periodic;
          n_gens_d   = n_gens;
          gen_d      = '0;
`ifdef CA_FIXPOINT_DETECT_EN
          fix_d      = 1'b0;
`endif
          fsm_d      = (n_gens != '0) ? StRun : StDone;
        end
      end
      StRun: begin
        if (abort) begin
          fsm_d = StDone;
        end else begin
          state_d = next_gen;
          gen_d   = gen_inc;
          if (gen_inc == n_gens_q) fsm_d = StDone;
`ifdef CA_FIXPOINT_DETECT_EN
          if (next_gen == state_q) begin
            fsm_d = StDone;
            fix_d = 1'b1;
          end
`endif
        end
      end
      StDone:  fsm_d = StIdle;
      default: fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q      <= StIdle;
      state_q    <= '0;
      gen_q      <= '0;
      n_gens_q   <= '0;
      rule_q     <= '0;
      periodic_q <= 1'b0;
`ifdef CA_FIXPOINT_DETECT_EN
      fix_q      <= 1'b0;
`endif
    end else begin
      fsm_q      <= fsm_d;
      state_q    <= state_d;
      gen_q      <= gen_d;
      n_gens_q   <= n_gens_d;
      rule_q     <= rule_d;
      periodic_q <= periodic_d;
`ifdef CA_FIXPOINT_DETECT_EN
      fix_q      <= fix_d;
`endif
    end
  end

  assign ready     = (fsm_q == StIdle);
  assign busy      = (fsm_q == StRun);
  assign done      = (fsm_q == StDone);
  assign state     = state_q;
  assign gen_count = gen_q;
`ifdef CA_FIXPOINT_DETECT_EN
  assign fixpoint  = fix_q;
`endif

endmodule

// File: tb/tb_wolfram_ca_engine.sv
// Self-checking bench for wolfram_ca_engine (WIDTH=8): directed cases plus random runs
// compared against a truth-table reference model of the automaton.
module tb_wolfram_ca_engine;
  localparam int W  = 8;
  localparam int GW = 16;

  logic          clk = 1'b0;
  logic          rst, periodic, load, start, abort;
  logic [7:0]    rule;
  logic [W-1:0]  seed;
  logic [GW-1:0] n_gens;
  logic          ready, busy, done;
  logic [W-1:0]  state;
  logic [GW-1:0] gen_count;
`ifdef CA_FIXPOINT_DETECT_EN
  logic          fixpoint;
`endif

  int checks = 0;
  int fails  = 0;

  wolfram_ca_engine #(.WIDTH(W), .GEN_W(GW)) dut (
    .clk       (clk),
    .rst       (rst),
    .rule      (rule),
    .periodic  (periodic),
    .load      (load),
    .seed      (seed),
    .start     (start),
    .n_gens    (n_gens),
    .abort     (abort),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .state     (state),
    .gen_count (gen_count)
`ifdef CA_FIXPOINT_DETECT_EN
    ,
    .fixpoint  (fixpoint)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: each cell looks up rule bit number 4*left + 2*center + right.
  function automatic logic [W-1:0] ref_step(input logic [W-1:0] s, input logic [7:0] r,
                                            input logic p);
    logic [W-1:0] n;
    int l, c, rt, idx;
    n = '0;
    for (int i = 0; i < W; i++) begin
      c = s[i] ? 1 : 0;
      if (i == W - 1) l = (p && s[0]) ? 1 : 0;
      else            l = s[i+1] ? 1 : 0;
      if (i == 0)     rt = (p && s[W-1]) ? 1 : 0;
      else            rt = s[i-1] ? 1 : 0;
      idx  = 4 * l + 2 * c + rt;
      n[i] = ((r >> idx) & 8'd1) != 8'd0;
    end
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] s);
    load = 1'b1;
    seed = s;
    tick();
    load = 1'b0;
    check("load", state, s);
  endtask

  // Full run with cycle-exact expectations for done/busy/ready/state.
  task automatic run_check(input string tag, input logic [W-1:0] s0, input logic [7:0] r,
                           input logic p, input int n);
    logic [W-1:0] seq[$];
    logic [W-1:0] nxt;
    int g, idx;
    logic fx;
    seq.push_back(s0);
    g  = n;
    fx = 1'b0;
    for (int k = 1; k <= n; k++) begin
      nxt = ref_step(seq[k-1], r, p);
      seq.push_back(nxt);
`ifdef CA_FIXPOINT_DETECT_EN
      if (nxt == seq[k-1]) begin
        g  = k;
        fx = 1'b1;
        break;
      end
`endif
    end
    do_load(s0);
    rule     = r;
    periodic = p;
    n_gens   = GW'(n);
    start    = 1'b1;
    tick();
    start    = 1'b0;
    // Configuration changes after start must not matter.
    rule     = ~r;
    periodic = ~p;
    n_gens   = GW'(n + 5);
    for (int c = 1; c <= g + 2; c++) begin
      if (c > 1) tick();
      idx = (c - 1 < g) ? c - 1 : g;
      check($sformatf("%s done c%0d", tag, c), done, c == g + 1);
      check($sformatf("%s busy c%0d", tag, c), busy, c <= g);
      check($sformatf("%s ready c%0d", tag, c), ready, c == g + 2);
      check($sformatf("%s state c%0d", tag, c), state, seq[idx]);
    end
    check({tag, " gen_count"}, gen_count, g);
`ifdef CA_FIXPOINT_DETECT_EN
    check({tag, " fixpoint"}, fixpoint, fx);
`endif
  endtask

  initial begin
    logic [W-1:0] e;
    rst = 1'b1; load = 1'b0; start = 1'b0; abort = 1'b0; periodic = 1'b0;
    rule = '0; seed = '0; n_gens = '0;
    tick();
    tick();
    check("rst ready", ready, 1'b1);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst state", state, '0);
    check("rst gen_count", gen_count, '0);
`ifdef CA_FIXPOINT_DETECT_EN
    check("rst fixpoint", fixpoint, 1'b0);
`endif
    rst = 1'b0;

    run_check("r5a", 8'h10, 8'h5A, 1'b1, 2);
    check("r5a final", state, 8'h44);
    run_check("raa_per", 8'h81, 8'hAA, 1'b1, 1);
    check("raa_per final", state, 8'h03);
    run_check("raa_null", 8'h81, 8'hAA, 1'b0, 1);
    check("raa_null final", state, 8'h02);
    run_check("zero_gens", 8'hC3, 8'h1E, 1'b1, 0);
    check("zero_gens final", state, 8'hC3);
    run_check("rcc", 8'h5A, 8'hCC, 1'b0, 10);
`ifdef CA_FIXPOINT_DETECT_EN
    check("rcc gens", gen_count, 1);
`else
    check("rcc gens", gen_count, 10);
`endif
    check("rcc final", state, 8'h5A);

    for (int t = 0; t < 8; t++) begin
      run_check($sformatf("rnd%0d", t), W'($urandom), 8'($urandom),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 12)));
    end

    // Reset in the middle of a run.
    do_load(8'h5A);
    rule = 8'h5A; periodic = 1'b0; n_gens = 16'd10; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("midrst busy before", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst ready", ready, 1'b1);
    check("midrst busy", busy, 1'b0);
    check("midrst done", done, 1'b0);
    check("midrst state", state, '0);
    check("midrst gen_count", gen_count, '0);

    // Abort after three generations; a load during the run is ignored.
    do_load(8'h96);
    rule = 8'h1E; periodic = 1'b1; n_gens = 16'd10; start = 1'b1;
    e = 8'h96;
    tick();
    start = 1'b0;
    load  = 1'b1;
    seed  = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      tick();
      load = 1'b0;
      e = ref_step(e, 8'h1E, 1'b1);
    end
    check("abort pre state", state, e);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort done", done, 1'b1);
    check("abort gen_count", gen_count, 3);
    check("abort state", state, e);
    tick();
    check("abort ready", ready, 1'b1);
    check("abort hold", state, e);

    // Abort in IDLE is ignored.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("idle abort done", done, 1'b0);
    check("idle abort ready", ready, 1'b1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
